// File: rtl/serial_addsub.sv
// serial_addsub
// Multi-cycle ripple adder/subtractor. Each clock it pushes one CHUNK-bit
// slice of the WIDTH-bit operands through a CHUNK-long full-adder chain and
// keeps the carry in a register between slices. The critical path is one
// CHUNK-bit ripple, whatever WIDTH is. WIDTH must be a multiple of CHUNK.
//
// Ports
//   clock    rising-edge clock
//   reset    asynchronous, active-high; clears all state and outputs
//   start    request an operation; honoured only while idle
//   sub      0: a + b + c_in   1: a - b (c_in ignored); sampled with start
//   a, b     operands, sampled with start
//   c_in     carry-in for add mode, sampled with start
//   busy     high while slices are being computed
//   done     one-cycle pulse when s / c_out / overflow are final
//   s        result (only the value present while done=1 is meaningful)
//   c_out    carry out of bit WIDTH-1; in sub mode 1 means no borrow
//   overflow signed overflow (carry into MSB xor carry out of MSB)
//
// state | meaning
// IDLE  | waiting for start; results of the last operation held
// RUN   | slice k computed each edge; last slice returns to IDLE with done

module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;   // carry into the top bit of the slice

  // Slice select uses constant part-selects so every index is static.
  always_comb begin
    logic c;
    slice_a    = '0;
    slice_b    = '0;
    slice_sum  = '0;
    slice_cmsb = 1'b0;
    c          = carry;
    for (int j = 0; j < N; j++) begin
      if (k == KW'(j)) begin
        slice_a = op_a[j*CHUNK +: CHUNK];
        slice_b = op_b[j*CHUNK +: CHUNK];
      end
    end
    for (int i = 0; i < CHUNK; i++) begin
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ c;
      if (i == CHUNK - 1) slice_cmsb = c;
      c = (slice_a[i] & slice_b[i]) | (slice_a[i] & c) | (slice_b[i] & c);
    end
    slice_cout = c;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s        <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a     <= a;
            // Subtraction as a + ~b + 1: the +1 rides in on the carry.
            op_b     <= sub ? ~b : b;
            carry    <= sub | c_in;
            s        <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            k        <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int j = 0; j < N; j++) begin
            if (k == KW'(j)) s[j*CHUNK +: CHUNK] <= slice_sum;
          end
          carry <= slice_cout;
          if (k == KW'(N - 1)) begin
            c_out    <= slice_cout;
            overflow <= slice_cmsb ^ slice_cout;
            k        <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // 8-bit, 2-bit slices (N=4)
  logic       st0 = 0, sub0 = 0, ci0 = 0;
  logic [7:0] a0 = 0, b0 = 0, s0;
  logic       busy0, done0, co0, ov0;
  // 16-bit, single slice (N=1)
  logic        st1 = 0, sub1 = 0, ci1 = 0;
  logic [15:0] a1 = 0, b1 = 0, s1;
  logic        busy1, done1, co1, ov1;
  // 16-bit, 4-bit slices (N=4)
  logic        st2 = 0, sub2 = 0, ci2 = 0;
  logic [15:0] a2 = 0, b2 = 0, s2;
  logic        busy2, done2, co2, ov2;

  serial_addsub #(.WIDTH(8), .CHUNK(2)) u0 (
    .clock(clock), .reset(reset), .start(st0), .sub(sub0), .a(a0), .b(b0),
    .c_in(ci0), .busy(busy0), .done(done0), .s(s0), .c_out(co0), .overflow(ov0));
  serial_addsub #(.WIDTH(16), .CHUNK(16)) u1 (
    .clock(clock), .reset(reset), .start(st1), .sub(sub1), .a(a1), .b(b1),
    .c_in(ci1), .busy(busy1), .done(done1), .s(s1), .c_out(co1), .overflow(ov1));
  serial_addsub #(.WIDTH(16), .CHUNK(4)) u2 (
    .clock(clock), .reset(reset), .start(st2), .sub(sub2), .a(a2), .b(b2),
    .c_in(ci2), .busy(busy2), .done(done2), .s(s2), .c_out(co2), .overflow(ov2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One full operation on the 8-bit instance, checking the handshake each cycle.
  task automatic run8(input string tag, input logic sb, input logic ci,
                      input logic [7:0] xa, input logic [7:0] xb,
                      input logic [7:0] es, input logic eco, input logic eov);
    sub0 = sb; ci0 = ci; a0 = xa; b0 = xb; st0 = 1'b1;
    tick;
    st0 = 1'b0;
    check({tag, " busy@accept"}, busy0, 1);
    check({tag, " done@accept"}, done0, 0);
    check({tag, " c_out cleared"}, co0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick;
      check($sformatf("%s busy@%0d", tag, i), busy0, (i < 4) ? 1 : 0);
      check($sformatf("%s done@%0d", tag, i), done0, (i == 4) ? 1 : 0);
    end
    check({tag, " s"}, s0, es);
    check({tag, " c_out"}, co0, eco);
    check({tag, " ovf"}, ov0, eov);
  endtask

  initial begin
    int n_done;
    // Reset state
    #12;
    check("rst busy", busy0, 0);
    check("rst done", done0, 0);
    check("rst s", s0, 0);
    check("rst c_out", co0, 0);
    check("rst ovf", ov0, 0);
    @(negedge clock);
    reset = 1'b0;
    tick;

    // Directed vectors, 8-bit / 2-bit slices
    run8("ff+01", 0, 0, 8'hFF, 8'h01, 8'h00, 1, 0);
    run8("5a+3c", 0, 0, 8'h5A, 8'h3C, 8'h96, 0, 1);
    run8("00+00+1", 0, 1, 8'h00, 8'h00, 8'h01, 0, 0);
    run8("10-20", 1, 0, 8'h10, 8'h20, 8'hF0, 0, 0);
    run8("80-01", 1, 0, 8'h80, 8'h01, 8'h7F, 1, 1);
    run8("10-20 cin", 1, 1, 8'h10, 8'h20, 8'hF0, 0, 0);
    check("hold s", s0, 8'hF0);

    // start while busy is ignored
    sub0 = 0; ci0 = 0; a0 = 8'h5A; b0 = 8'h3C; st0 = 1;
    tick;
    st0 = 0;
    tick;
    check("partial s", s0, 8'h02);
    tick;
    a0 = 8'hFF; b0 = 8'h01; sub0 = 1; st0 = 1;
    tick;
    st0 = 0;
    check("ign done@3", done0, 0);
    tick;
    check("ign done@4", done0, 1);
    check("ign s", s0, 8'h96);
    check("ign ovf", ov0, 1);
    tick;
    check("ign no restart", busy0, 0);

    // start in the done cycle is accepted
    sub0 = 0; ci0 = 0; a0 = 8'h11; b0 = 8'h22; st0 = 1;
    tick;
    st0 = 0;
    for (int i = 0; i < 3; i++) tick;
    tick;
    check("b2b first done", done0, 1);
    check("b2b first s", s0, 8'h33);
    sub0 = 1; a0 = 8'h80; b0 = 8'h01; st0 = 1;
    tick;
    st0 = 0;
    check("b2b accepted", busy0, 1);
    for (int i = 0; i < 3; i++) tick;
    check("b2b no early done", done0, 0);
    tick;
    check("b2b second done", done0, 1);
    check("b2b second s", s0, 8'h7F);
    check("b2b second c_out", co0, 1);

    // asynchronous reset during slice 2
    tick;
    sub0 = 0; ci0 = 0; a0 = 8'h5A; b0 = 8'h3C; st0 = 1;
    tick;
    st0 = 0;
    tick;
    tick;
    check("pre-rst s", s0, 8'h06);
    #3 reset = 1'b1;
    #1;
    check("arst busy", busy0, 0);
    check("arst s", s0, 0);
    check("arst done", done0, 0);
    check("arst c_out", co0, 0);
    check("arst ovf", ov0, 0);
    #1 reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done0) n_done++;
    end
    check("arst no done", n_done, 0);
    run8("after rst", 0, 0, 8'h5A, 8'h3C, 8'h96, 0, 1);

    // 16-bit single slice
    a1 = 16'h7FFF; b1 = 16'h0001; sub1 = 0; ci1 = 0; st1 = 1;
    tick;
    st1 = 0;
    check("w16c16 busy", busy1, 1);
    tick;
    check("w16c16 done", done1, 1);
    check("w16c16 s", s1, 16'h8000);
    check("w16c16 ovf", ov1, 1);
    check("w16c16 c_out", co1, 0);
    tick;
    check("w16c16 done pulse", done1, 0);

    // 16-bit, 4-bit slices
    a2 = 16'hFFFF; b2 = 16'h0001; sub2 = 0; ci2 = 0; st2 = 1;
    tick;
    st2 = 0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      check($sformatf("w16c4 done@%0d", i), done2, (i == 4) ? 1 : 0);
    end
    check("w16c4 s", s2, 16'h0000);
    check("w16c4 c_out", co2, 1);
    check("w16c4 ovf", ov2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
